qam16_frame_ctrl: RTL and testbench

- Sequences a stream of 3-bit I/Q samples through the external combinational 16-QAM symbol decoder (inphase/quad in, 4-bit Gray symbol out).
- Hunts for a two-symbol sync word, then packs decoded symbol pairs into payload bytes for a configured frame length.
- Sits between the IQ sample source and the byte-level framer; adds valid/ready flow control, frame bookkeeping and code-error detection.

---
 rtl/qam16_frame_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_qam16_frame_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qam16_frame_ctrl.sv
// 16-QAM frame controller: stages I/Q samples into the external decoder, hunts for the
// two-symbol sync word, then packs symbol pairs into payload bytes with valid/ready flow.
module qam16_frame_ctrl #(
  parameter int unsigned       IN_W    = 3,
  parameter int unsigned       SYM_W   = 4,
  parameter logic [SYM_W-1:0]  SYNC_HI = 4'hA,
  parameter logic [SYM_W-1:0]  SYNC_LO = 4'h5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [7:0]       frame_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  inphase,
  input  logic [IN_W-1:0]  quad,
  output logic [IN_W-1:0]  dec_inphase,
  output logic [IN_W-1:0]  dec_quad,
  input  logic [SYM_W-1:0] dec_symbol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             frame_start,
  output logic             frame_done,
  output logic             frame_err,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {StIdle, StHunt, StPayload} state_e;

  state_e           state_q, state_d;
  logic             s1_valid_q;
  logic [IN_W-1:0]  dec_inphase_q, dec_quad_q;
  logic             hi_seen_q, hi_seen_d;
  logic             nibble_half_q, nibble_half_d;
  logic [SYM_W-1:0] hi_nib_q, hi_nib_d;
  logic [7:0]       byte_cnt_q, byte_cnt_d;
  logic [7:0]       len_q, len_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_err_q, frame_err_d;
  logic [7:0]       err_cnt_q;
  logic             out_valid_q;
  logic [7:0]       out_byte_q;

  logic code_ok, byte_complete, s1_adv, in_ready_c, accept, load;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      hi_seen_q     <= 1'b0;
      nibble_half_q <= 1'b0;
      hi_nib_q      <= '0;
      byte_cnt_q    <= '0;
      len_q         <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hi_seen_q     <= hi_seen_d;
      nibble_half_q <= nibble_half_d;
      hi_nib_q      <= hi_nib_d;
      byte_cnt_q    <= byte_cnt_d;
      len_q         <= len_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
    end
  end

  // Next-state logic; a symbol is processed only in a cycle where s1 advances
  always_comb begin
    state_d       = state_q;
    hi_seen_d     = hi_seen_q;
    nibble_half_d = nibble_half_q;
    hi_nib_d      = hi_nib_q;
    byte_cnt_d    = byte_cnt_q;
    len_d         = len_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StHunt;
      end
      StHunt: begin
        if (s1_adv) begin
          if (!code_ok) begin
            hi_seen_d = 1'b0;
          end else if (hi_seen_q && dec_symbol == SYNC_LO) begin
            state_d       = StPayload;
            len_d         = frame_len;
            byte_cnt_d    = '0;
            nibble_half_d = 1'b0;
            hi_seen_d     = 1'b0;
            frame_start_d = 1'b1;
          end else begin
            hi_seen_d = (dec_symbol == SYNC_HI);
          end
        end
      end
      StPayload: begin
        if (len_q == 8'd0) begin
          // Empty frame closes at once; any staged symbol is treated as hunt input
          frame_done_d = 1'b1;
          state_d      = StHunt;
          if (s1_adv) hi_seen_d = code_ok && (dec_symbol == SYNC_HI);
        end else if (s1_adv) begin
          if (!code_ok) begin
            nibble_half_d = 1'b0;
            frame_err_d   = 1'b1;
            state_d       = StHunt;
          end else if (!nibble_half_q) begin
            hi_nib_d      = dec_symbol;
            nibble_half_d = 1'b1;
          end else begin
            nibble_half_d = 1'b0;
            byte_cnt_d    = byte_cnt_q + 8'd1;
            if (byte_cnt_q + 8'd1 == len_q) begin
              frame_done_d = 1'b1;
              state_d      = StHunt;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Disable abort waits until the staged sample has been processed
    if (state_q != StIdle && !enable && !s1_valid_q) begin
      state_d       = StIdle;
      hi_seen_d     = 1'b0;
      nibble_half_d = 1'b0;
      byte_cnt_d    = '0;
    end
  end

  // Output / handshake logic
  always_comb begin
    code_ok       = dec_inphase_q[0] & dec_quad_q[0];
    byte_complete = s1_valid_q && (state_q == StPayload) && nibble_half_q && code_ok;
    s1_adv        = s1_valid_q && (!byte_complete || !out_valid_q || out_ready);
    in_ready_c    = enable && (state_q != StIdle) && (!s1_valid_q || s1_adv);
    accept        = in_valid && in_ready_c;
    load          = s1_adv && byte_complete;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      dec_inphase_q <= '0;
      dec_quad_q    <= '0;
      out_valid_q   <= 1'b0;
      out_byte_q    <= '0;
      err_cnt_q     <= '0;
    end else begin
      if (accept) begin
        s1_valid_q    <= 1'b1;
        dec_inphase_q <= inphase;
        dec_quad_q    <= quad;
      end else if (s1_adv) begin
        s1_valid_q <= 1'b0;
      end
      if (load) begin
        out_valid_q <= 1'b1;
        out_byte_q  <= {hi_nib_q, dec_symbol};
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (s1_adv && !code_ok && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign in_ready    = in_ready_c;
  assign dec_inphase = dec_inphase_q;
  assign dec_quad    = dec_quad_q;
  assign out_valid   = out_valid_q;
  assign out_byte    = out_byte_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_qam16_frame_ctrl.sv
// Bench for qam16_frame_ctrl: Gray 16-QAM decoder model, cycle vector table for the basic
// frame, then hand-written sequences for back-pressure, sync, error and abort corners.
module tb_qam16_frame_ctrl;

  localparam logic [2:0] M3 = 3'b101;
  localparam logic [2:0] M1 = 3'b111;
  localparam logic [2:0] P1 = 3'b001;
  localparam logic [2:0] P3 = 3'b011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] frame_len;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] inphase, quad;
  logic [2:0] dec_inphase, dec_quad;
  logic [3:0] dec_symbol;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       frame_start, frame_done, frame_err;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [1:0] gray2(input logic [2:0] v);
    case (v)
      3'b101:  return 2'b00;
      3'b111:  return 2'b01;
      3'b001:  return 2'b11;
      3'b011:  return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  assign dec_symbol = {gray2(dec_inphase), gray2(dec_quad)};

  qam16_frame_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .frame_len   (frame_len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .inphase     (inphase),
    .quad        (quad),
    .dec_inphase (dec_inphase),
    .dec_quad    (dec_quad),
    .dec_symbol  (dec_symbol),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_byte    (out_byte),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .err_cnt     (err_cnt)
  );

  // Event monitor
  int         cyc = 0, fs_cnt = 0, fd_cnt = 0, fe_cnt = 0, ov_cnt = 0, fs_cyc = 0, fd_cyc = 0;
  logic [7:0] rx_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      cyc = cyc + 1;
      if (frame_start) begin fs_cnt = fs_cnt + 1; fs_cyc = cyc; end
      if (frame_done) begin fd_cnt = fd_cnt + 1; fd_cyc = cyc; end
      if (frame_err) fe_cnt = fe_cnt + 1;
      if (out_valid) ov_cnt = ov_cnt + 1;
      if (out_valid && out_ready) rx_q.push_back(out_byte);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [2:0] i, input logic [2:0] q);
    int t = 0;
    in_valid = 1'b1;
    inphase  = i;
    quad     = q;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", t);
        break;
      end
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, {31'b0, in_ready}, 0);
    check({tag, "_dec_iq"}, {26'b0, dec_inphase, dec_quad}, 0);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 0);
    check({tag, "_out_byte"}, {24'b0, out_byte}, 0);
    check({tag, "_pulses"}, {29'b0, frame_start, frame_done, frame_err}, 0);
    check({tag, "_err_cnt"}, {24'b0, err_cnt}, 0);
  endtask

  typedef struct {
    logic       iv;
    logic [2:0] i;
    logic [2:0] q;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_ob;
    logic       e_fs;
    logic       e_fd;
  } vec_t;

  initial begin
    vec_t tbl[9];
    int fs0, fd0, fe0, ov0;
    bit saw_low;
    int t;

    // Sync word, two payload bytes 8'h01 and 8'hFA, frame_len = 2
    tbl[0] = '{1'b1, P3, P3, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{1'b1, M1, M1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{1'b1, M3, M3, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{1'b1, M3, M1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[4] = '{1'b1, P1, P1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[5] = '{1'b1, P3, P3, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 3'b0, 3'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 3'b0, 3'b0, 1'b1, 1'b1, 1'b1, 8'hFA, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 3'b0, 3'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};

    rst_n = 1'b0; enable = 1'b0; frame_len = 8'd0; in_valid = 1'b0;
    inphase = '0; quad = '0; out_ready = 1'b0;
    idle(2);
    check_all_zero("reset");
    rst_n = 1'b1; enable = 1'b1; frame_len = 8'd2; out_ready = 1'b1;
    @(negedge clk);
    check("idle_in_ready", {31'b0, in_ready}, 0);
    step();

    for (int k = 0; k < 9; k++) begin
      in_valid  = tbl[k].iv;
      inphase   = tbl[k].i;
      quad      = tbl[k].q;
      out_ready = tbl[k].ordy;
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", k), {31'b0, in_ready}, {31'b0, tbl[k].e_ir});
      check($sformatf("vec%0d_out_valid", k), {31'b0, out_valid}, {31'b0, tbl[k].e_ov});
      if (tbl[k].e_ov) check($sformatf("vec%0d_out_byte", k), {24'b0, out_byte},
                             {24'b0, tbl[k].e_ob});
      check($sformatf("vec%0d_frame_start", k), {31'b0, frame_start}, {31'b0, tbl[k].e_fs});
      check($sformatf("vec%0d_frame_done", k), {31'b0, frame_done}, {31'b0, tbl[k].e_fd});
      step();
    end

    // Back-pressure: output held for 5 cycles after the first byte
    rx_q.delete();
    fd0 = fd_cnt;
    out_ready = 1'b0;
    saw_low = 1'b0;
    fork
      begin
        send(P3, P3); send(M1, M1); send(M3, M3);
        send(M3, M1); send(P1, P1); send(P3, P3);
      end
      begin
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 50) begin @(negedge clk); t++; end
        for (int k = 0; k < 5; k++) begin
          check($sformatf("bp_hold%0d_valid", k), {31'b0, out_valid}, 1);
          check($sformatf("bp_hold%0d_byte", k), {24'b0, out_byte}, 32'h01);
          if (!in_ready) saw_low = 1'b1;
          @(negedge clk);
        end
        step();
        out_ready = 1'b1;
      end
    join
    idle(6);
    check("bp_in_ready_dropped", {31'b0, saw_low}, 1);
    check("bp_byte_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check("bp_byte0", {24'b0, rx_q[0]}, 32'h01);
      check("bp_byte1", {24'b0, rx_q[1]}, 32'hFA);
    end
    check("bp_frame_done", fd_cnt - fd0, 1);

    // Repeated SYNC_HI, with a zero-length frame
    frame_len = 8'd0;
    rx_q.delete();
    fs0 = fs_cnt; fd0 = fd_cnt; ov0 = ov_cnt;
    send(P3, P3); send(P3, P3);
    idle(3);
    check("sync_hi_hi_no_start", fs_cnt - fs0, 0);
    send(M1, M1);
    idle(3);
    check("sync_rep_start", fs_cnt - fs0, 1);
    check("zero_len_done", fd_cnt - fd0, 1);
    check("zero_len_consecutive", fd_cyc - fs_cyc, 1);
    check("zero_len_no_valid", ov_cnt - ov0, 0);
    fs0 = fs_cnt;
    send(P3, P3); send(P1, P1); send(M1, M1);
    idle(3);
    check("broken_sync_no_start", fs_cnt - fs0, 0);

    // Bad code after one payload nibble
    frame_len = 8'd2;
    rx_q.delete();
    check("err_cnt_before", {24'b0, err_cnt}, 0);
    fs0 = fs_cnt; fd0 = fd_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    send(P3, P3); send(M1, M1); send(M3, M3); send(3'b010, P1);
    idle(3);
    check("bad_frame_err", fe_cnt - fe0, 1);
    check("bad_err_cnt", {24'b0, err_cnt}, 1);
    check("bad_no_byte", ov_cnt - ov0, 0);
    send(P3, P3); send(M1, M1); send(M3, M1); send(P1, P1); send(P3, P3); send(M3, M3);
    idle(4);
    check("resync_start", fs_cnt - fs0, 2);
    check("resync_done", fd_cnt - fd0, 1);
    check("resync_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check("resync_byte0", {24'b0, rx_q[0]}, 32'h1F);
      check("resync_byte1", {24'b0, rx_q[1]}, 32'hA0);
    end

    // Enable drop after one nibble
    rx_q.delete();
    send(P3, P3); send(M1, M1); send(M3, M3);
    enable = 1'b0;
    @(negedge clk);
    check("dis_in_ready", {31'b0, in_ready}, 0);
    idle(3);
    enable = 1'b1;
    @(negedge clk);
    check("dis_idle_in_ready", {31'b0, in_ready}, 0);
    step();
    @(negedge clk);
    check("reen_in_ready", {31'b0, in_ready}, 1);
    step();
    send(M3, M1); send(P1, P1);
    idle(3);
    check("dis_nibble_dropped", rx_q.size(), 0);
    send(P3, P3); send(M1, M1); send(P1, P1); send(P3, P3); send(P1, P1); send(P3, P3);
    idle(4);
    check("reen_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check("reen_byte0", {24'b0, rx_q[0]}, 32'hFA);
      check("reen_byte1", {24'b0, rx_q[1]}, 32'hFA);
    end

    // Error counter saturation
    for (int k = 0; k < 10; k++) send(3'b000, 3'b000);
    idle(3);
    check("err_cnt_11", {24'b0, err_cnt}, 11);
    for (int k = 0; k < 290; k++) send(3'b000, 3'b000);
    idle(3);
    check("err_cnt_sat", {24'b0, err_cnt}, 255);

    // Asynchronous reset with a pending output byte
    out_ready = 1'b0;
    send(P3, P3); send(M1, M1); send(M3, M3); send(M3, M1);
    idle(2);
    check("pre_rst_valid", {31'b0, out_valid}, 1);
    check("pre_rst_byte", {24'b0, out_byte}, 32'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    idle(2);
    rst_n = 1'b1;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
